// File: rtl/paddle_controller.sv
// paddle_controller: debounced buttons drive a per-frame paddle position with optional acceleration.
// Build option: define PADDLE_ACCEL_EN to enable the speed ramp; otherwise speed stays at BASE_SPEED.
module paddle_controller #(
  parameter int PADDLE_LENGTH_PIXEL = 60,
  parameter int MIN_X               = 10,
  parameter int MAX_X               = 730,
  parameter int START_X             = 370,
  parameter int BASE_SPEED          = 2,
  parameter int MAX_SPEED           = 8,
  parameter int RAMP_FRAMES         = 4,
  parameter int DEBOUNCE_CYCLES     = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       VSYNC,
  output logic [9:0] PADDLE_X_PIXEL,
  output logic       MOVING
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SMAX = (MAX_SPEED > BASE_SPEED) ? MAX_SPEED : BASE_SPEED;
  localparam int SW   = $clog2(SMAX + 1);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  logic [1:0] raw, s1_q, s2_q, deb;
  state_t state_q, state_d;
  logic vs_q, moving_q, chg, tick;
  logic [9:0] x_q, x_d;
  logic [SW-1:0] spd_q, spd_use;
  logic [10:0] xw, sw;
  assign raw = {BTN_RIGHT, BTN_LEFT};
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic deb_q;
    always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (s2_q[b] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        deb_q <= ~deb_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    assign deb[b] = deb_q;
  end
  always_comb begin
    state_d = (deb[0] == deb[1]) ? IDLE : deb[0] ? LEFT : RIGHT;
    chg     = state_d != state_q;
    tick    = VSYNC & ~vs_q;
    spd_use = chg ? SW'(BASE_SPEED) : spd_q;
    xw      = {1'b0, x_q};
    sw      = 11'(spd_use);
    x_d     = !tick ? x_q :
              state_d == LEFT  ? ((xw < 11'(MIN_X) + sw) ? 10'(MIN_X) : 10'(xw - sw)) :
              state_d == RIGHT ? ((xw + sw > 11'(MAX_X)) ? 10'(MAX_X) : 10'(xw + sw)) :
              x_q;
  end
`ifdef PADDLE_ACCEL_EN
  localparam int RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [SW-1:0] spd_d;
  logic step, wrap;
  always_comb begin
    step   = tick && state_d != IDLE;
    wrap   = ramp_q == RW'(RAMP_FRAMES - 1);
    ramp_d = chg ? '0 : !step ? ramp_q : wrap ? '0 : ramp_q + 1'b1;
    spd_d  = chg ? SW'(BASE_SPEED) :
             !(step && wrap) ? spd_q :
             (spd_q >= SW'(MAX_SPEED)) ? SW'(MAX_SPEED) : spd_q + 1'b1;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      ramp_q <= '0;
      spd_q  <= SW'(BASE_SPEED);
    end else begin
      ramp_q <= ramp_d;
      spd_q  <= spd_d;
    end
`else
  assign spd_q = SW'(BASE_SPEED);
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q  <= IDLE;
      vs_q     <= 1'b0;
      x_q      <= 10'(START_X);
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= VSYNC;
      x_q      <= x_d;
      moving_q <= state_q != IDLE;
    end
  assign PADDLE_X_PIXEL = x_q;
  assign MOVING         = moving_q;
endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller: directed and random button/VSYNC stimulus against a frame-level paddle model.
module tb_paddle_controller;
  localparam int MINX = 10, MAXX = 730, STARTX = 370, BASE = 2, MAXS = 8, RAMP = 4;
  logic clk, rst, btn_l, btn_r, vsync, moving;
  logic [9:0] x;
  int n_cmp, n_err;
  int mx, mspd, mramp, mdir;
  int cur_l, cur_r;
  paddle_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(clk), .RESET(rst), .BTN_LEFT(btn_l), .BTN_RIGHT(btn_r),
    .VSYNC(vsync), .PADDLE_X_PIXEL(x), .MOVING(moving)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mx = STARTX; mspd = BASE; mramp = 0; mdir = 0;
  endtask
  task automatic set_btn(input int l, input int r);
    int nd;
    btn_l = l[0]; btn_r = r[0]; cur_l = l; cur_r = r;
    repeat (12) @(negedge clk);
    nd = (l == r) ? 0 : (l != 0) ? 1 : 2;
    if (nd != mdir) begin mdir = nd; mspd = BASE; mramp = 0; end
    chk("settle_moving", 32'(moving), 32'(mdir != 0));
    chk("settle_x", 32'(x), 32'(mx));
  endtask
  task automatic glitch(input int which, input int len);
    if (which == 0) btn_l = ~btn_l; else btn_r = ~btn_r;
    repeat (len) @(negedge clk);
    btn_l = cur_l[0]; btn_r = cur_r[0];
    repeat (12) @(negedge clk);
    chk("glitch_moving", 32'(moving), 32'(mdir != 0));
    chk("glitch_x", 32'(x), 32'(mx));
  endtask
  task automatic model_frame();
    if (mdir == 1) mx = (mx - mspd < MINX) ? MINX : mx - mspd;
    if (mdir == 2) mx = (mx + mspd > MAXX) ? MAXX : mx + mspd;
`ifdef PADDLE_ACCEL_EN
    if (mdir != 0) begin
      if (mramp == RAMP - 1) begin
        mramp = 0;
        mspd = (mspd + 1 > MAXS) ? MAXS : mspd + 1;
      end else mramp++;
    end
`endif
  endtask
  task automatic frame(input int hi, input int lo);
    vsync = 1'b1;
    chk("pre_tick_x", 32'(x), 32'(mx));
    @(negedge clk);
    model_frame();
    chk("tick_x", 32'(x), 32'(mx));
    repeat (hi - 1) @(negedge clk);
    chk("hold_x", 32'(x), 32'(mx));
    vsync = 1'b0;
    repeat (lo) @(negedge clk);
    chk("low_x", 32'(x), 32'(mx));
  endtask
  initial begin
    int exp_run [8];
`ifdef PADDLE_ACCEL_EN
    exp_run = '{372, 374, 376, 378, 381, 384, 387, 390};
`else
    exp_run = '{372, 374, 376, 378, 380, 382, 384, 386};
`endif
    n_cmp = 0; n_err = 0;
    rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; vsync = 1'b0; cur_l = 0; cur_r = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_x", 32'(x), 32'(STARTX));
    chk("reset_moving", 32'(moving), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    set_btn(0, 1);
    for (int i = 0; i < 5; i++) begin
      frame(3, 3);
      chk("ramp_run5", 32'(x), 32'(exp_run[i]));
    end
    vsync = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_x", 32'(x), 32'(STARTX));
    chk("async_reset_moving", 32'(moving), 32'd0);
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_btn(0, 1);
    for (int i = 0; i < 8; i++) begin
      frame(1 + i, 2);
      chk("ramp_run8", 32'(x), 32'(exp_run[i]));
    end
    set_btn(1, 1);
    frame(4, 3);
    frame(2, 3);
    chk("both_frozen", 32'(x), 32'(exp_run[7]));
    set_btn(1, 0);
    for (int i = 0; i < 3; i++) begin
      frame(2, 3);
      chk("left_base", 32'(x), 32'(exp_run[7] - 2 * (i + 1)));
    end
    set_btn(0, 0);
    glitch(1, 3);
    frame(2, 2);
    chk("pulse_ignored_moving", 32'(moving), 32'd0);
    set_btn(1, 0);
    for (int i = 0; i < 200; i++) frame(1, 2);
    chk("left_wall", 32'(x), 32'(MINX));
    chk("left_wall_moving", 32'(moving), 32'd1);
    set_btn(0, 1);
    for (int i = 0; i < 400; i++) frame(1, 2);
    chk("right_wall", 32'(x), 32'(MAXX));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      set_btn(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 6)) frame(int'($urandom_range(1, 8)), int'($urandom_range(2, 6)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/paddle_controller.md
# paddle_controller

Converts the two raw paddle push-buttons into the paddle's horizontal pixel position consumed by the game renderer's `PADDLE_X_PIXEL` input. It synchronises and debounces the buttons and runs a small direction state machine. Position is updated once per frame on the rising edge of the renderer's `VSYNC`, so the paddle is stable for the whole visible frame. Motion accelerates while a direction is held and is clamped against the side walls.

## Interface
Parameters:
- `PADDLE_LENGTH_PIXEL`, 60: paddle width in pixels; must match the renderer.
- `MIN_X`, 10: leftmost legal position, the first pixel right of the left wall block.
- `MAX_X`, 730: rightmost legal position, equal to 790 − `PADDLE_LENGTH_PIXEL`.
- `START_X`, 370: position after reset.
- `BASE_SPEED`, 2: initial speed in px/frame.
- `MAX_SPEED`, 8: speed ceiling in px/frame.
- `RAMP_FRAMES`, 4: number of moving frames per +1 px/frame speed step.
- `DEBOUNCE_CYCLES`, 50000: number of consecutive stable cycles required to accept a button level change.

Ports:
- `CLK` input, 1: system clock; same clock as the renderer.
- `RESET` input, 1: asynchronous, active-high reset.
- `BTN_LEFT` input, 1: raw, asynchronous left button, active-high.
- `BTN_RIGHT` input, 1: raw, asynchronous right button, active-high.
- `VSYNC` input, 1: renderer `VSYNC`, synchronous to `CLK`.
- `PADDLE_X_PIXEL` output, 10: registered left edge of the paddle.
- `MOVING` output, 1: registered; high when the state is not IDLE.

## Operation
- Each button passes through a 2-FF synchroniser and then a debouncer.
  - Debouncer: a counter compares the synchronised level against the debounced level.
  - Any mismatch counts up; the debounced level flips once `DEBOUNCE_CYCLES` consecutive mismatching cycles are reached.
  - A match clears the counter.
- State machine, evaluated every cycle from the debounced levels (L, R):
  - IDLE when L=R, both released or both pressed.
  - LEFT when L=1 and R=0.
  - RIGHT when L=0 and R=1.
- Any state change loads speed ← `BASE_SPEED` and clears the ramp counter in the same cycle.
- Frame tick: `VSYNC` is high now and was low in the previous cycle. Detection uses a one-register delay of `VSYNC`.
- On a frame tick in LEFT:
  - X ← max(X − speed, `MIN_X`).
  - Arithmetic is done in 11 bits; if X < `MIN_X` + speed, X is set to `MIN_X`.
- On a frame tick in RIGHT:
  - X ← min(X + speed, `MAX_X`).
  - Arithmetic is done in 11 bits; if X + speed > `MAX_X`, X is set to `MAX_X`.
- Speed ramp on a moving frame tick:
  - The move uses the current speed first.
  - Then the ramp counter increments. When it reaches `RAMP_FRAMES` − 1, it clears and speed becomes min(speed+1, `MAX_SPEED`).
  - The new speed applies from the next frame.
- Reaching a wall does not stop the ramp. X simply stays clamped.
- A frame tick in IDLE leaves X, speed and the ramp counter unchanged.
- Simultaneous state change and frame tick: the move uses the new state with `BASE_SPEED`.

## Timing
- Reset values: `PADDLE_X_PIXEL` = `START_X`, `MOVING` = 0.
- Internal reset values: debounced levels 0, synchroniser flops 0, `VSYNC` delay register 0, speed `BASE_SPEED`, ramp counter 0, state IDLE.
- Reset takes effect immediately and asynchronously, including mid-frame and mid-move.
- Latency from a raw button edge to the state change: 2 synchroniser cycles + `DEBOUNCE_CYCLES`. `MOVING` follows one cycle later.
- `PADDLE_X_PIXEL` changes exactly one cycle after the `VSYNC` rising edge, at most once per frame. It is held constant otherwise.
- A `VSYNC` held high for many cycles produces exactly one tick.

## Configuration
- `PADDLE_ACCEL_EN` defined: the speed ramp operates as described above.
- `PADDLE_ACCEL_EN` undefined: the ramp counter and increment logic are removed, and speed stays at `BASE_SPEED` permanently. `MAX_SPEED` and `RAMP_FRAMES` are then ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and the defaults otherwise, with `PADDLE_ACCEL_EN` defined unless stated.
- Assert `RESET` mid-move at X=381 → X reads 370 and `MOVING` reads 0 in the same cycle, before the next `CLK` edge.
- Hold `BTN_RIGHT`, then issue 6 `VSYNC` rising edges → X = 372, 374, 376, 378, 381, 384, each change one cycle after its edge.
- Hold `BTN_LEFT` from X=14 → X goes 12, 10, 10, and `MOVING` stays 1.
- Pulse `BTN_RIGHT` for 3 cycles, then keep it low → debounced level stays 0 and X stays 370 across frames.
- Hold right for 5 frames, then additionally press left → state IDLE, X frozen. Release right → moves left at 2 px/frame.
- Same bench with `PADDLE_ACCEL_EN` undefined, hold right for 8 frames → X = 386, a constant 2 px/frame.
